// File: rtl/add.sv
`default_nettype none
// ============================================================================
// Module      : add
// Description : Registered two's-complement adder/subtractor with carry,
//               zero, negative and signed-overflow status flags. One result
//               per cycle, one-cycle latency, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module add #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          opt_sub,
    input  logic          cin,
    output logic          out_valid,
    output logic [DW-1:0] sum,
    output logic          cout,
    output logic          zero,
    output logic          neg,
    output logic          overflow
);

    // Subtraction is a + ~b + 1; the borrow-in removes that +1, so the
    // effective carry-in is the inverted borrow.
    logic [DW-1:0] w_b_eff;
    logic          w_c0;
    logic [DW:0]   w_full;
    logic [DW-1:0] w_low;
    logic          w_carry_msb;
    logic [DW-1:0] w_s;
    logic          w_c_out;
    logic          w_zero;
    logic          w_neg;
    logic          w_overflow;

    // Registered outputs
    logic          r_out_valid;
    logic [DW-1:0] r_sum;
    logic          r_cout;
    logic          r_zero;
    logic          r_neg;
    logic          r_overflow;

    // Operand conditioning, full-width sum and flag derivation
    always_comb begin
        w_b_eff     = opt_sub ? ~b : b;
        w_c0        = opt_sub ? ~cin : cin;
        w_full      = {1'b0, a} + {1'b0, w_b_eff} + {{DW{1'b0}}, w_c0};
        // Sum of the low DW-1 bits; its top bit is the carry into the MSB.
        w_low       = {1'b0, a[DW-2:0]} + {1'b0, w_b_eff[DW-2:0]}
                    + {{(DW-1){1'b0}}, w_c0};
        w_carry_msb = w_low[DW-1];
        w_s         = w_full[DW-1:0];
        w_c_out     = w_full[DW];
        w_zero      = (w_s == '0);
        w_neg       = w_s[DW-1];
        w_overflow  = w_carry_msb ^ w_c_out;
    end

    // Capture result and flags on accepted operations; hold otherwise
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum      <= w_s;
                r_cout     <= w_c_out;
                r_zero     <= w_zero;
                r_neg      <= w_neg;
                r_overflow <= w_overflow;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_add
// Description : Self-checking bench for add (DW=4) using a table of
//               hand-computed vectors plus hold and mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add;

    localparam int DW = 4;

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          opt_sub;
    logic          cin;
    logic          out_valid;
    logic [DW-1:0] sum;
    logic          cout;
    logic          zero;
    logic          neg;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sub;
        logic          cin;
        logic [DW-1:0] e_sum;
        logic          e_cout;
        logic          e_zero;
        logic          e_neg;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [9];

    add #(.DW(DW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opt_sub   (opt_sub),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic ov, input logic [DW-1:0] s,
                                 input logic c, input logic z, input logic n, input logic o);
        check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, ov});
        check({tag, ".sum"},       {4'b0, sum},       {4'b0, s});
        check({tag, ".cout"},      {7'b0, cout},      {7'b0, c});
        check({tag, ".zero"},      {7'b0, zero},      {7'b0, z});
        check({tag, ".neg"},       {7'b0, neg},       {7'b0, n});
        check({tag, ".overflow"},  {7'b0, overflow},  {7'b0, o});
    endtask

    task automatic drive(input vec_t v, input logic vld);
        a        = v.a;
        b        = v.b;
        opt_sub  = v.sub;
        cin      = v.cin;
        in_valid = vld;
    endtask

    initial begin
        //          a        b        sub   cin   sum      cout  zero  neg   ovf
        vecs[0] = '{4'b0011, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0111, 4'b0101, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{4'b0100, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0010, 4'b0101, 1'b1, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0101, 4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{4'b0100, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held with arbitrary active inputs
        nreset   = 1'b0;
        in_valid = 1'b1;
        a        = 4'b1010;
        b        = 4'b0110;
        opt_sub  = 1'b1;
        cin      = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_outputs("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release with in_valid low: outputs stay cleared
        @(negedge clk);
        nreset   = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outputs("idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back table: each result appears exactly one edge later
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
            @(posedge clk);
            #1 check_outputs($sformatf("vec%0d", i), 1'b1, vecs[i].e_sum,
                             vecs[i].e_cout, vecs[i].e_zero, vecs[i].e_neg, vecs[i].e_ovf);
        end

        // Hold: in_valid low with changing operands keeps last result
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(vecs[i + 1], 1'b0);
            @(posedge clk);
            #1 check_outputs($sformatf("hold%0d", i), 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Mid-stream reset: clears between edges, pending operation dropped
        @(negedge clk);
        drive(vecs[1], 1'b1);
        @(posedge clk);
        #1 check_outputs("pre_rst", 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(vecs[5], 1'b1);
        #2 nreset = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_outputs("rst_edge", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nreset   = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check_outputs("post_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // First operation after reset recovery
        @(negedge clk);
        drive(vecs[0], 1'b1);
        @(posedge clk);
        #1 check_outputs("recover", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add.md
Name: add

Overview:
Parameterized registered two's-complement adder/subtractor with ALU status flags (carry, zero, negative, signed overflow). It is used as the arithmetic core of datapath/ALU blocks. It computes a ± b with carry/borrow-in and registers result and flags with one-cycle latency.

Parameters:
DW  4  operand and result width in bits (must be ≥ 2)

Ports:
clk  input  1  clock, all state updates on rising edge
nreset  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle; result captured only when high
a  input  DW  first operand (unsigned or two's-complement)
b  input  DW  second operand
opt_sub  input  1  0 = add, 1 = subtract (a − b)
cin  input  1  add: carry-in; subtract: borrow-in
out_valid  output  1  registered in_valid; high the cycle after an accepted operation
sum  output  DW  registered result
cout  output  1  registered carry-out (subtract: 1 = no borrow)
zero  output  1  registered, 1 when sum == 0
neg  output  1  registered, equals sum[DW-1]
overflow  output  1  registered signed overflow

Behaviour:
- Reset: clock and reset are fixed: one clock, clk; reset nreset is asynchronous and active-low. While nreset low, out_valid, sum, cout, zero, neg, overflow all 0 immediately, independent of clk. Release is synchronous to next rising clk.
- Combinational core:
  - b_eff = opt_sub ? ~b : b
  - c0 = opt_sub ? ~cin : cin
  - {c_out, s} = a + b_eff + c0, computed at DW+1 bits with no truncation.
  - Add gives a + b + cin; subtract gives a − b − cin.
- Flags:
  - cout = c_out.
  - zero = (s == 0).
  - neg = s[DW-1].
  - overflow = carry into bit DW-1 XOR c_out. This equals sign(a) == sign(b_eff) && sign(s) != sign(a).
- Registering:
  - On rising clk with in_valid=1, capture s and all flags into output registers. Latency is exactly 1 cycle.
  - On rising clk with in_valid=0, hold sum and flags at their previous values.
  - out_valid <= in_valid every cycle.
- Back-to-back operations: one result per cycle, no stalls, no internal state beyond the output registers.
- Wrap-around: the result is modulo 2^DW. Unsigned overflow is reported only via cout. Signed overflow is reported only via overflow.
- Subtract boundaries:
  - a == b with cin=0 → sum 0, zero=1, cout=1.
  - a < b (unsigned) → cout=0.
  - Subtracting the most-negative value from a non-negative a → overflow=1.
- Reset asserted mid-stream: all outputs clear at once. A pending in_valid in that cycle is discarded.

Test Plan:
- Reset: nreset=0 with arbitrary inputs → all outputs 0 asynchronously. After release, hold in_valid=0 → outputs stay 0.
- Add, DW=4: a=0011, b=0001, opt_sub=0, cin=0, in_valid=1 → next cycle sum=0100, cout=0, zero=0, neg=0, overflow=0, out_valid=1. Then a=0111, b=0101, cin=1 → sum=1101, cout=0, neg=1, overflow=1.
- Subtract: a=0100, b=0011, opt_sub=1, cin=0 → sum=0001, cout=1, neg=0, overflow=0. Then a=0010, b=0101 → sum=1101, cout=0, neg=1, overflow=0. Then a=0101, b=0101 → sum=0000, zero=1, cout=1.
- Overflow/wrap: a=0111, b=0001, add → sum=1000, neg=1, overflow=1, cout=0. Then a=1111, b=0001 → sum=0000, zero=1, cout=1, overflow=0. Subtract a=0000, b=1000 → sum=1000, overflow=1.
- Borrow-in and hold: subtract a=0100, b=0011, cin=1 → sum=0000, zero=1, cout=1. Then in_valid=0 for 3 cycles with changing a/b → outputs unchanged, out_valid=0.
- Back-to-back plus reset: apply the add sequence on consecutive cycles → each result appears exactly 1 cycle later. Assert nreset mid-sequence between clock edges → outputs clear immediately.
